// File: rtl/idex_pipe_reg_if.sv
// ID/EX pipeline register bundle.
// Carries the decode-side hazard controls (stall, flush, in_valid), the decoded
// instruction fields (*_in), the registered EX-side fields (*_out) and the two
// activity counters.
//   slave  : the pipeline register. It samples the controls and *_in fields and
//            drives valid_out, the *_out fields and the counters.
//   master : the decode/EX environment, which sees the opposite directions.
interface idex_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  branch_in, mem_read_in, mem_write_in;
    logic                  alu_src_in, reg_write_in, mem_to_reg_in;
    logic [ALU_OP_W-1:0]   alu_op_in;
    logic [DATA_W-1:0]     rs_data_in, rt_data_in, imm_in, pc_in;
    logic [REG_ADDR_W-1:0] rd_in;

    logic                  valid_out;
    logic                  branch_out, mem_read_out, mem_write_out;
    logic                  alu_src_out, reg_write_out, mem_to_reg_out;
    logic [ALU_OP_W-1:0]   alu_op_out;
    logic [DATA_W-1:0]     rs_data_out, rt_data_out, imm_out, pc_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [CNT_W-1:0]      stall_cnt, bubble_cnt;

    modport master (
        output stall, flush, in_valid,
               branch_in, mem_read_in, mem_write_in, alu_src_in, reg_write_in, mem_to_reg_in,
               alu_op_in, rs_data_in, rt_data_in, imm_in, pc_in, rd_in,
        input  valid_out,
               branch_out, mem_read_out, mem_write_out, alu_src_out, reg_write_out, mem_to_reg_out,
               alu_op_out, rs_data_out, rt_data_out, imm_out, pc_out, rd_out,
               stall_cnt, bubble_cnt
    );

    modport slave (
        input  stall, flush, in_valid,
               branch_in, mem_read_in, mem_write_in, alu_src_in, reg_write_in, mem_to_reg_in,
               alu_op_in, rs_data_in, rt_data_in, imm_in, pc_in, rd_in,
        output valid_out,
               branch_out, mem_read_out, mem_write_out, alu_src_out, reg_write_out, mem_to_reg_out,
               alu_op_out, rs_data_out, rt_data_out, imm_out, pc_out, rd_out,
               stall_cnt, bubble_cnt
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall (hold) and flush (bubble).
// The edge priority is reset, then flush, then stall, then load. An input with
// in_valid=0 loads as a bubble. A bubble zeroes every field, so it can never
// raise branch, memory or register-write side effects downstream.
// Ports:
//   clk_i  : clock; all state updates happen on the rising edge
//   rst_i  : synchronous active-high reset; clears the fields and both counters
//   bus    : idex_pipe_reg_if.slave; controls and *_in in, *_out and counters out
// stall_cnt counts edges where a stall was honoured. bubble_cnt counts bubbles
// forced by flush. Both saturate at all-ones.
// Every output comes straight from a flop.
module idex_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 6,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    idex_pipe_reg_if.slave  bus
);
    typedef struct packed {
        logic                  branch;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [DATA_W-1:0]     rs_data;
        logic [DATA_W-1:0]     rt_data;
        logic [DATA_W-1:0]     imm;
        logic [DATA_W-1:0]     pc;
        logic [REG_ADDR_W-1:0] rd;
    } payload_t;

    payload_t         pay_q, pay_d, pay_in;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign pay_in = '{
        branch:     bus.branch_in,
        mem_read:   bus.mem_read_in,
        mem_write:  bus.mem_write_in,
        alu_src:    bus.alu_src_in,
        reg_write:  bus.reg_write_in,
        mem_to_reg: bus.mem_to_reg_in,
        alu_op:     bus.alu_op_in,
        rs_data:    bus.rs_data_in,
        rt_data:    bus.rt_data_in,
        imm:        bus.imm_in,
        pc:         bus.pc_in,
        rd:         bus.rd_in
    };

    always_comb begin
        pay_d        = pay_q;
        valid_d      = valid_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.flush) begin
            // Flush wins over stall. The stall is not counted on this edge.
            pay_d   = '0;
            valid_d = 1'b0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (bus.stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (bus.in_valid) begin
            pay_d   = pay_in;
            valid_d = 1'b1;
        end else begin
            // Natural bubble from decode. It is not counted as a flush bubble.
            pay_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pay_q        <= '0;
            valid_q      <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pay_q        <= pay_d;
            valid_q      <= valid_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.valid_out      = valid_q;
    assign bus.branch_out     = pay_q.branch;
    assign bus.mem_read_out   = pay_q.mem_read;
    assign bus.mem_write_out  = pay_q.mem_write;
    assign bus.alu_src_out    = pay_q.alu_src;
    assign bus.reg_write_out  = pay_q.reg_write;
    assign bus.mem_to_reg_out = pay_q.mem_to_reg;
    assign bus.alu_op_out     = pay_q.alu_op;
    assign bus.rs_data_out    = pay_q.rs_data;
    assign bus.rt_data_out    = pay_q.rt_data;
    assign bus.imm_out        = pay_q.imm;
    assign bus.pc_out         = pay_q.pc;
    assign bus.rd_out         = pay_q.rd;
    assign bus.stall_cnt      = stall_cnt_q;
    assign bus.bubble_cnt     = bubble_cnt_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
module tb_idex_pipe_reg;
    localparam int DW = 32, AW = 6, OW = 2, CW = 4;

    typedef struct packed {
        logic          valid;
        logic [5:0]    ctrl;   // branch, mem_read, mem_write, alu_src, reg_write, mem_to_reg
        logic [OW-1:0] alu_op;
        logic [DW-1:0] rs, rt, imm, pc;
        logic [AW-1:0] rd;
        logic [CW-1:0] sc, bc;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    total = 0;
    int    bad = 0;
    snap_t m = '0;
    snap_t sb[$];
    snap_t e, o;

    idex_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_OP_W(OW), .CNT_W(CW)) bus ();

    idex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_OP_W(OW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic snap_t observe();
        snap_t s;
        s.valid  = bus.valid_out;
        s.ctrl   = {bus.branch_out, bus.mem_read_out, bus.mem_write_out,
                    bus.alu_src_out, bus.reg_write_out, bus.mem_to_reg_out};
        s.alu_op = bus.alu_op_out;
        s.rs     = bus.rs_data_out;
        s.rt     = bus.rt_data_out;
        s.imm    = bus.imm_out;
        s.pc     = bus.pc_out;
        s.rd     = bus.rd_out;
        s.sc     = bus.stall_cnt;
        s.bc     = bus.bubble_cnt;
        return s;
    endfunction

    // Reference behaviour for one rising edge, written from the operating rules.
    function automatic snap_t model(snap_t cur);
        snap_t n;
        n = cur;
        if (rst) begin
            n = '0;
        end else if (bus.flush) begin
            n = '0;
            n.sc = cur.sc;
            n.bc = (cur.bc == 4'hF) ? 4'hF : cur.bc + 4'd1;
        end else if (bus.stall) begin
            n.sc = (cur.sc == 4'hF) ? 4'hF : cur.sc + 4'd1;
        end else if (bus.in_valid) begin
            n.valid  = 1'b1;
            n.ctrl   = {bus.branch_in, bus.mem_read_in, bus.mem_write_in,
                        bus.alu_src_in, bus.reg_write_in, bus.mem_to_reg_in};
            n.alu_op = bus.alu_op_in;
            n.rs     = bus.rs_data_in;
            n.rt     = bus.rt_data_in;
            n.imm    = bus.imm_in;
            n.pc     = bus.pc_in;
            n.rd     = bus.rd_in;
        end else begin
            n = '0;
            n.sc = cur.sc;
            n.bc = cur.bc;
        end
        return n;
    endfunction

    // Push the expected post-edge state, then advance past the edge.
    task automatic cyc();
        m = model(m);
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        {bus.branch_in, bus.mem_read_in, bus.mem_write_in,
         bus.alu_src_in, bus.reg_write_in, bus.mem_to_reg_in} = 6'($urandom());
        bus.alu_op_in  = 2'($urandom());
        bus.rs_data_in = $urandom();
        bus.rt_data_in = $urandom();
        bus.imm_in     = $urandom();
        bus.pc_in      = $urandom();
        bus.rd_in      = 6'($urandom());
    endtask

    task automatic clear_fields();
        {bus.branch_in, bus.mem_read_in, bus.mem_write_in,
         bus.alu_src_in, bus.reg_write_in, bus.mem_to_reg_in} = 6'b0;
        bus.alu_op_in  = '0;
        bus.rs_data_in = '0;
        bus.rt_data_in = '0;
        bus.imm_in     = '0;
        bus.pc_in      = '0;
        bus.rd_in      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b1; rand_fields();
        for (int i = 0; i < 2; i++) begin
            cyc();
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL reset_state got=%h want=%h", o, e); end
        end
        rst = 1'b0; clear_fields(); bus.in_valid = 1'b1;
        bus.rs_data_in = 32'h0000_1234; bus.rd_in = 6'd5; bus.mem_read_in = 1'b1; bus.alu_op_in = 2'b10;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL first_load got=%h want=%h", o, e); end
        total++;
        if ({bus.valid_out, bus.rs_data_out, bus.rd_out, bus.mem_read_out, bus.alu_op_out}
            !== {1'b1, 32'h1234, 6'd5, 1'b1, 2'b10}) begin
            bad++; $display("FAIL first_load_fields rs=%h rd=%0d got_valid=%b", bus.rs_data_out, bus.rd_out, bus.valid_out);
        end
    endtask

    task automatic test_stall_hold();
        bus.pc_in = 32'h40; bus.in_valid = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL stall_load got=%h want=%h", o, e); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_in = 32'h44 + 32'(4 * i); bus.rs_data_in = $urandom();
            cyc();
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e || bus.pc_out !== 32'h40) begin
                bad++; $display("FAIL stall_hold got=%h want=%h", o, e);
            end
        end
        total++;
        if (bus.stall_cnt !== 4'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", bus.stall_cnt); end
        bus.stall = 1'b0; bus.pc_in = 32'h50;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e || bus.pc_out !== 32'h50) begin
            bad++; $display("FAIL stall_release got pc=%h want pc=00000050", bus.pc_out);
        end
    endtask

    task automatic test_flush_over_stall();
        rand_fields(); bus.mem_write_in = 1'b1; bus.in_valid = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL flush_preload got=%h want=%h", o, e); end
        bus.stall = 1'b1; bus.flush = 1'b1; rand_fields();
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL flush_over_stall got=%h want=%h", o, e); end
        total++;
        if ({bus.valid_out, bus.mem_write_out, bus.rs_data_out, bus.pc_out, bus.bubble_cnt, bus.stall_cnt}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 4'd1, 4'd3}) begin
            bad++; $display("FAIL flush_fields got bc=%0d sc=%0d valid=%b want bc=1 sc=3 valid=0",
                            bus.bubble_cnt, bus.stall_cnt, bus.valid_out);
        end
        bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_invalid_input();
        rand_fields(); bus.in_valid = 1'b0; bus.reg_write_in = 1'b1; bus.branch_in = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL invalid_input got=%h want=%h", o, e); end
        total++;
        if ({bus.valid_out, bus.reg_write_out, bus.branch_out, bus.bubble_cnt} !== {3'b000, 4'd1}) begin
            bad++; $display("FAIL invalid_fields got v/rw/br=%b%b%b bc=%0d want 000 bc=1",
                            bus.valid_out, bus.reg_write_out, bus.branch_out, bus.bubble_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            rand_fields();
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.stall    = ($urandom_range(0, 2) == 0);
            bus.flush    = ($urandom_range(0, 4) == 0);
            rst          = ($urandom_range(0, 19) == 0);
            cyc();
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL random_%0d got=%h want=%h", i, o, e); end
        end
        rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL sat_reset got=%h want=%h", o, e); end
        rst = 1'b0; bus.stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL stall_sat_%0d got=%h want=%h", i, o, e); end
        end
        total++;
        if (bus.stall_cnt !== 4'hF) begin bad++; $display("FAIL stall_cnt_sat got=%0d want=15", bus.stall_cnt); end
        bus.stall = 1'b0; bus.flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_fields(); bus.in_valid = 1'b1;
            cyc();
            e = sb.pop_front(); o = observe(); total++;
            if (o !== e) begin bad++; $display("FAIL flush_sat_%0d got=%h want=%h", i, o, e); end
        end
        total++;
        if (bus.bubble_cnt !== 4'hF || bus.stall_cnt !== 4'hF) begin
            bad++; $display("FAIL bubble_cnt_sat got bc=%0d sc=%0d want 15/15", bus.bubble_cnt, bus.stall_cnt);
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        rand_fields(); bus.in_valid = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e) begin bad++; $display("FAIL pre_rst_load got=%h want=%h", o, e); end
        bus.stall = 1'b1; rst = 1'b1;
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e || o !== snap_t'(0)) begin bad++; $display("FAIL reset_mid_stall got=%h want=0", o); end
        rst = 1'b0; bus.stall = 1'b0; rand_fields();
        cyc();
        e = sb.pop_front(); o = observe(); total++;
        if (o !== e || bus.valid_out !== 1'b1) begin bad++; $display("FAIL post_rst_load got=%h want=%h", o, e); end
    endtask

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        clear_fields();
        @(negedge clk);
        test_reset();
        test_stall_hold();
        test_flush_over_stall();
        test_invalid_input();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
